rom_stream_loader: RTL and testbench
====================================

Name: rom_stream_loader

Overview:
Clocked, parametrised ROM loader that copies a program byte stream into CHIP-8 main memory through a synchronous write port. An optional font-table preload runs first. The block holds the CPU in reset until the image is resident and raises a sticky done or error flag. It sits between the host-side byte source (DPI shim or UART/SPI front end) and the memory write mux ahead of the CPU core.

Parameters:
ADDR_W, 12, memory address width in bits
DATA_W, 8, memory and stream data width
MEM_DEPTH, 4096, number of addressable memory words; must be ≤ 2**ADDR_W
LOAD_BASE, 'h200, first address written with program data
FONT_EN, 1, 1 = preload the font table before the program
FONT_BASE, 'h050, first address of the font table
FONT_LEN, 80, number of font bytes (16 glyphs × 5)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
start_in  input  1  one-cycle pulse that begins a load
rom_len_in  input  ADDR_W+1  expected program length in bytes, sampled on start
s_data_in  input  DATA_W  stream byte
s_valid_in  input  1  stream byte valid
s_last_in  input  1  marks the final byte, qualified by s_valid_in
s_ready_out  output  1  loader accepts the stream byte this cycle
mem_we_out  output  1  memory write enable
mem_addr_out  output  ADDR_W  memory write address
mem_wdata_out  output  DATA_W  memory write data
cpu_hold_out  output  1  holds the CPU in reset while loading
busy_out  output  1  FSM is not in IDLE, DONE or ERROR
done_out  output  1  sticky load-complete flag
error_out  output  1  sticky overflow flag
count_out  output  ADDR_W+1  program bytes written so far

Behaviour:
- Reset (asynchronous, active-low):
  - FSM enters IDLE.
  - All outputs are 0, except cpu_hold_out = 1.
  - count and font index are 0.
  - Reset asserted mid-load aborts immediately. Partial memory contents are left as-is.
- States: IDLE, FONT, LOAD, DONE, ERROR.
- start_in is honoured only in IDLE, DONE or ERROR; it is ignored while busy. On start:
  - latch rom_len_in and clear count, done and error.
  - go to FONT if FONT_EN, else to LOAD.
- FONT state:
  - one write per cycle: mem_addr = FONT_BASE + idx, mem_wdata = font[idx].
  - after idx = FONT_LEN-1, go to LOAD.
  - s_ready_out = 0 throughout.
- LOAD state:
  - s_ready_out = 1 combinationally in LOAD.
  - A handshake (s_valid_in & s_ready_out) registers a write on the next edge: mem_we_out = 1, mem_addr_out = LOAD_BASE + count, mem_wdata_out = s_data_in. Latency is 1 cycle from handshake to write strobe. count increments on the same edge.
  - Exit when the accepted byte has s_last_in = 1, or count+1 == latched length. Either condition goes to DONE; whichever occurs first wins.
  - If the latched length is 0, LOAD exits to DONE after one cycle with no writes and s_ready_out = 0.
- Overflow: a handshake with LOAD_BASE + count ≥ MEM_DEPTH causes:
  - no write; the byte is consumed and dropped.
  - transition to ERROR and error_out = 1.
- Address arithmetic uses ADDR_W+1 bits internally, so the compare is never wrapped.
- DONE state:
  - done_out = 1, cpu_hold_out = 0, s_ready_out = 0.
  - stays until the next start.
- ERROR state:
  - error_out = 1, cpu_hold_out = 1, s_ready_out = 0.
  - exits only on start or reset.
- mem_we_out is a single-cycle strobe per byte. Font and program writes never overlap in the same cycle.
- Stream bytes presented outside LOAD are not consumed and are held by the source.
- busy_out = 1 exactly in FONT and LOAD.

Decomposition:
- Package loader_pkg:
  - loader_state_t enum (IDLE, FONT, LOAD, DONE, ERROR).
  - FONT_TABLE constant: 80 × 8-bit standard CHIP-8 hex glyphs 0–F.
  - default base-address localparams.
- Sub-module font_rom: combinational index → byte lookup into FONT_TABLE, instantiated once.

Test Plan:
1. FONT_EN=1, start with len=4, stream AA,BB,CC,DD without gaps →
   - 80 font writes at 050..09F, with byte 0 = F0 at 050.
   - then writes AA@200, BB@201, CC@202, DD@203.
   - done_out=1, cpu_hold_out=0, count_out=4.
2. FONT_EN=0, len=8, stream 3 bytes with s_last on byte 3, valid toggling every other cycle → 3 writes at 200..202, DONE, count_out=3, no write while valid is low.
3. LOAD_BASE='hFFE, len=4, stream 4 bytes →
   - writes at FFE and FFF.
   - third byte dropped, error_out=1, cpu_hold_out=1, no write at address 000.
4. len=0 start → no program writes; DONE with count_out=0.
5. Assert rst_n_in low for 1 cycle after 2 program bytes → all outputs reset immediately (cpu_hold_out=1). A new start reloads from 200 with count_out restarting at 1.
6. Pulse start_in mid-LOAD → ignored; the load completes normally and count is not cleared.

Source files
------------

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the ROM stream loader.
//   loader_state_t : loader FSM states
//   FONT_TABLE     : the 16 standard CHIP-8 hex glyphs (0-F), 5 bytes each
//   DEFAULT_*      : default base addresses for program and font data
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FONT  = 3'd1,
        LOAD  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    localparam int DEFAULT_LOAD_BASE = 'h200;
    localparam int DEFAULT_FONT_BASE = 'h050;

    // Font index width; FONT_TABLE_LEN entries fit in 7 bits.
    localparam int FONT_IDX_W     = 7;
    localparam int FONT_TABLE_LEN = 80;

    // Element 0 is the first row of glyph 0; glyph n starts at element 5*n.
    localparam logic [0:FONT_TABLE_LEN-1][7:0] FONT_TABLE = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
    };

endpackage

// File: rtl/font_rom.sv
// ---------------------------------------------------------------------------
// font_rom
// Combinational lookup of one CHIP-8 font byte by index.
//   i_idx  : byte index into the font table
//   o_data : font byte at i_idx (0 for indices past the end of the table)
// ---------------------------------------------------------------------------
module font_rom
    import loader_pkg::*;
(
    input  logic [FONT_IDX_W-1:0] i_idx,
    output logic [7:0]            o_data
);

    // Indices beyond the table return 0 so the lookup never reads outside
    // the constant array.
    always_comb begin
        o_data = 8'h00;
        if (i_idx < FONT_IDX_W'(FONT_TABLE_LEN)) begin
            o_data = FONT_TABLE[i_idx];
        end
    end

endmodule

// File: rtl/rom_stream_loader.sv
// ---------------------------------------------------------------------------
// rom_stream_loader
// Copies a program byte stream into CHIP-8 main memory through a synchronous
// write port, optionally preloading the font table first. The CPU is held in
// reset until the image is resident; done/error flags are sticky until the
// next start.
//
// Ports:
//   clk_in, rst_n_in      : clock, asynchronous active-low reset
//   start_in              : one-cycle pulse that begins a load (IDLE/DONE/ERROR)
//   rom_len_in            : expected program length in bytes, sampled on start
//   s_data_in/s_valid_in/s_last_in/s_ready_out : byte stream handshake
//   mem_we_out/mem_addr_out/mem_wdata_out      : registered memory write port
//   cpu_hold_out          : high except when the load has completed cleanly
//   busy_out              : high in FONT and LOAD
//   done_out, error_out   : sticky completion / overflow flags
//   count_out             : program bytes written so far
// ---------------------------------------------------------------------------
module rom_stream_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 4096,
    parameter int LOAD_BASE = DEFAULT_LOAD_BASE,
    parameter int FONT_EN   = 1,
    parameter int FONT_BASE = DEFAULT_FONT_BASE,
    parameter int FONT_LEN  = FONT_TABLE_LEN
)
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic [ADDR_W:0]   rom_len_in,
    input  logic [DATA_W-1:0] s_data_in,
    input  logic              s_valid_in,
    input  logic              s_last_in,
    output logic              s_ready_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    output logic              cpu_hold_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out,
    output logic [ADDR_W:0]   count_out
);

    // Program addresses and counts carry one extra bit so the end-of-memory
    // compare sees the true sum instead of a wrapped address.
    localparam int CW = ADDR_W + 1;

    localparam logic [CW-1:0]         C_LOAD_BASE = CW'(LOAD_BASE);
    localparam logic [CW-1:0]         C_MEM_DEPTH = CW'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0]     C_FONT_BASE = ADDR_W'(FONT_BASE);
    localparam logic [FONT_IDX_W-1:0] C_FONT_LAST = FONT_IDX_W'(FONT_LEN - 1);

    loader_state_t r_state;
    loader_state_t w_stateNext;

    logic [CW-1:0]         r_len;
    logic [CW-1:0]         r_count;
    logic [FONT_IDX_W-1:0] r_idx;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_done;
    logic                  r_error;

    logic                  w_start;
    logic                  w_ready;
    logic                  w_handshake;
    logic [CW-1:0]         w_progAddr;
    logic                  w_overflow;
    logic [CW-1:0]         w_countInc;
    logic                  w_lenHit;
    logic [7:0]            w_fontByte;

    font_rom u_font_rom (
        .i_idx  (r_idx),
        .o_data (w_fontByte)
    );

    // A start pulse is only honoured while the loader is not busy.
    assign w_start = start_in &&
                     ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));

    // A zero-length load never accepts a byte; it just passes through LOAD.
    assign w_ready     = (r_state == LOAD) && (r_len != '0);
    assign w_handshake = s_valid_in && w_ready;

    assign w_progAddr  = C_LOAD_BASE + r_count;
    assign w_overflow  = (w_progAddr >= C_MEM_DEPTH);
    assign w_countInc  = r_count + 1'b1;
    assign w_lenHit    = (w_countInc == r_len);

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. Overflow has priority over the end-of-image checks
    // so a dropped byte always lands in ERROR.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (w_start) begin
                    w_stateNext = (FONT_EN != 0) ? FONT : LOAD;
                end
            end
            FONT: begin
                if (r_idx == C_FONT_LAST) begin
                    w_stateNext = LOAD;
                end
            end
            LOAD: begin
                if (r_len == '0) begin
                    w_stateNext = DONE;
                end else if (w_handshake) begin
                    if (w_overflow) begin
                        w_stateNext = ERROR;
                    end else if (s_last_in || w_lenHit) begin
                        w_stateNext = DONE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath: the write port is registered, so every write strobe appears
    // one cycle after the FONT step or stream handshake that produced it.
    // Font writes come from FONT and program writes from LOAD, so the two
    // can never share a cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_len   <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_len   <= rom_len_in;
                r_count <= '0;
                r_idx   <= '0;
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end else begin
                case (r_state)
                    FONT: begin
                        r_we    <= 1'b1;
                        r_addr  <= C_FONT_BASE + ADDR_W'(r_idx);
                        r_wdata <= DATA_W'(w_fontByte);
                        r_idx   <= r_idx + 1'b1;
                    end
                    LOAD: begin
                        if (w_handshake && !w_overflow) begin
                            r_we    <= 1'b1;
                            r_addr  <= w_progAddr[ADDR_W-1:0];
                            r_wdata <= s_data_in;
                            r_count <= w_countInc;
                        end
                        if (w_stateNext == DONE) begin
                            r_done <= 1'b1;
                        end
                        if (w_stateNext == ERROR) begin
                            r_error <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign s_ready_out   = w_ready;
    assign mem_we_out    = r_we;
    assign mem_addr_out  = r_addr;
    assign mem_wdata_out = r_wdata;
    assign cpu_hold_out  = (r_state != DONE);
    assign busy_out      = (r_state == FONT) || (r_state == LOAD);
    assign done_out      = r_done;
    assign error_out     = r_error;
    assign count_out     = r_count;

endmodule

// File: tb/tb_rom_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_rom_stream_loader
// Three loader instances share clock and reset:
//   dut 0 : font preload enabled, program at 'h200
//   dut 1 : no font preload, program at 'h200
//   dut 2 : no font preload, program at 'hFFE (runs off the end of memory)
// Expected memory writes are queued when stimulus is issued; a monitor pops
// one entry for every write strobe seen on any instance.
// ---------------------------------------------------------------------------
module tb_rom_stream_loader;

    localparam int LW = 13;

    logic clk = 1'b0;
    logic rstN;

    logic [2:0]    start;
    logic [2:0]    sValid;
    logic [2:0]    sLast;
    logic [LW-1:0] romLen [3];
    logic [7:0]    sData  [3];

    wire  [2:0]    sReady;
    wire  [2:0]    memWe;
    wire  [2:0]    cpuHold;
    wire  [2:0]    busy;
    wire  [2:0]    done;
    wire  [2:0]    error;
    wire  [11:0]   memAddr  [3];
    wire  [7:0]    memWdata [3];
    wire  [LW-1:0] count    [3];

    typedef struct {
        int         dut;
        logic [11:0] addr;
        logic [7:0]  data;
    } wrExp_t;

    wrExp_t expQ[$];

    int totalCount = 0;
    int badCount   = 0;

    localparam logic [7:0] FONT_REF [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rom_stream_loader #(
            .ADDR_W    (12),
            .DATA_W    (8),
            .MEM_DEPTH (4096),
            .LOAD_BASE ((g == 2) ? 'hFFE : 'h200),
            .FONT_EN   ((g == 0) ? 1 : 0),
            .FONT_BASE ('h050),
            .FONT_LEN  (80)
        ) u_dut (
            .clk_in        (clk),
            .rst_n_in      (rstN),
            .start_in      (start[g]),
            .rom_len_in    (romLen[g]),
            .s_data_in     (sData[g]),
            .s_valid_in    (sValid[g]),
            .s_last_in     (sLast[g]),
            .s_ready_out   (sReady[g]),
            .mem_we_out    (memWe[g]),
            .mem_addr_out  (memAddr[g]),
            .mem_wdata_out (memWdata[g]),
            .cpu_hold_out  (cpuHold[g]),
            .busy_out      (busy[g]),
            .done_out      (done[g]),
            .error_out     (error[g]),
            .count_out     (count[g])
        );
    end

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushWrite(input int d, input logic [11:0] a, input logic [7:0] v);
        wrExp_t e;
        e.dut  = d;
        e.addr = a;
        e.data = v;
        expQ.push_back(e);
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input int d, input int len);
        romLen[d] = LW'(len);
        start[d]  = 1'b1;
        tick(1);
        start[d]  = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it, bounded.
    task automatic sendByte(input int d, input logic [7:0] v, input bit last,
                            input bit expWrite, input logic [11:0] addr);
        sData[d]  = v;
        sLast[d]  = last;
        sValid[d] = 1'b1;
        if (expWrite) pushWrite(d, addr, v);
        for (int i = 0; i < 300; i++) begin
            if (sReady[d]) begin
                tick(1);
                sValid[d] = 1'b0;
                sLast[d]  = 1'b0;
                return;
            end
            tick(1);
        end
        sValid[d] = 1'b0;
        sLast[d]  = 1'b0;
        checkOutput("sendTimeout", 32'd1, 32'd0);
    endtask

    // Monitor: each write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (memWe[g] === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWrite", {20'd0, memAddr[g]}, 32'hFFFF_FFFF);
                end else begin
                    wrExp_t e;
                    e = expQ.pop_front();
                    checkOutput("wrDut",  g,           e.dut);
                    checkOutput("wrAddr", memAddr[g],  e.addr);
                    checkOutput("wrData", memWdata[g], e.data);
                end
            end
        end
    end

    task automatic applyStimulus();
        // Reset values while reset is held.
        #1;
        for (int g = 0; g < 3; g++) begin
            checkOutput("rstHold",  cpuHold[g], 1);
            checkOutput("rstWe",    memWe[g],   0);
            checkOutput("rstBusy",  busy[g],    0);
            checkOutput("rstDone",  done[g],    0);
            checkOutput("rstErr",   error[g],   0);
            checkOutput("rstCount", count[g],   0);
            checkOutput("rstReady", sReady[g],  0);
        end
        tick(2);
        rstN = 1'b1;
        tick(1);

        // Font preload then a four-byte program with no gaps.
        $display("[TB] font preload + 4 byte load");
        for (int i = 0; i < 80; i++) pushWrite(0, 12'h050 + 12'(i), FONT_REF[i]);
        pulseStart(0, 4);
        checkOutput("fontBusy",  busy[0],    1);
        checkOutput("fontReady", sReady[0],  0);
        checkOutput("fontHold",  cpuHold[0], 1);
        sendByte(0, 8'hAA, 1'b0, 1'b1, 12'h200);
        sendByte(0, 8'hBB, 1'b0, 1'b1, 12'h201);
        sendByte(0, 8'hCC, 1'b0, 1'b1, 12'h202);
        sendByte(0, 8'hDD, 1'b0, 1'b1, 12'h203);
        checkOutput("t1Done",  done[0],    1);
        checkOutput("t1Hold",  cpuHold[0], 0);
        checkOutput("t1Count", count[0],   4);
        checkOutput("t1Busy",  busy[0],    0);
        tick(2);

        // s_last ends the load early; valid toggles between bytes.
        $display("[TB] s_last with gapped valid");
        pulseStart(1, 8);
        checkOutput("t2Ready", sReady[1], 1);
        sendByte(1, 8'h11, 1'b0, 1'b1, 12'h200);
        tick(1);
        sendByte(1, 8'h22, 1'b0, 1'b1, 12'h201);
        tick(1);
        sendByte(1, 8'h33, 1'b1, 1'b1, 12'h202);
        checkOutput("t2Done",  done[1],    1);
        checkOutput("t2Count", count[1],   3);
        checkOutput("t2Hold",  cpuHold[1], 0);
        tick(2);

        // Program runs off the end of memory.
        $display("[TB] overflow at end of memory");
        pulseStart(2, 4);
        sendByte(2, 8'hA1, 1'b0, 1'b1, 12'hFFE);
        sendByte(2, 8'hA2, 1'b0, 1'b1, 12'hFFF);
        sendByte(2, 8'hA3, 1'b0, 1'b0, 12'h000);
        checkOutput("t3Err",   error[2],   1);
        checkOutput("t3Hold",  cpuHold[2], 1);
        checkOutput("t3Done",  done[2],    0);
        checkOutput("t3Count", count[2],   2);
        checkOutput("t3Busy",  busy[2],    0);
        sData[2]  = 8'hA4;
        sValid[2] = 1'b1;
        tick(3);
        checkOutput("t3Ready", sReady[2], 0);
        sValid[2] = 1'b0;
        tick(1);

        // Zero-length load.
        $display("[TB] zero length load");
        pulseStart(1, 0);
        checkOutput("t4Ready", sReady[1], 0);
        checkOutput("t4Busy",  busy[1],   1);
        checkOutput("t4DoneClr", done[1], 0);
        tick(1);
        checkOutput("t4Done",  done[1],    1);
        checkOutput("t4Count", count[1],   0);
        checkOutput("t4Hold",  cpuHold[1], 0);
        tick(2);

        // Reset in the middle of a load, then reload.
        $display("[TB] reset mid-load");
        pulseStart(1, 6);
        sendByte(1, 8'h41, 1'b0, 1'b1, 12'h200);
        sendByte(1, 8'h42, 1'b0, 1'b1, 12'h201);
        tick(1);
        rstN = 1'b0;
        #1;
        checkOutput("t5Hold",  cpuHold[1], 1);
        checkOutput("t5Busy",  busy[1],    0);
        checkOutput("t5Count", count[1],   0);
        checkOutput("t5Ready", sReady[1],  0);
        checkOutput("t5Done0", done[0],    0);
        tick(1);
        rstN = 1'b1;
        tick(1);
        pulseStart(1, 6);
        sendByte(1, 8'h5A, 1'b0, 1'b1, 12'h200);
        checkOutput("t5Count1", count[1], 1);
        sendByte(1, 8'h5B, 1'b1, 1'b1, 12'h201);
        checkOutput("t5Done", done[1], 1);
        tick(2);

        // A start pulse while busy is ignored.
        $display("[TB] start ignored while busy");
        pulseStart(1, 3);
        sendByte(1, 8'h61, 1'b0, 1'b1, 12'h200);
        pulseStart(1, 1);
        checkOutput("t6Count", count[1], 1);
        checkOutput("t6Busy",  busy[1],  1);
        sendByte(1, 8'h62, 1'b0, 1'b1, 12'h201);
        sendByte(1, 8'h63, 1'b0, 1'b1, 12'h202);
        checkOutput("t6Done",  done[1],  1);
        checkOutput("t6CountEnd", count[1], 3);
        tick(3);

        checkOutput("queueEmpty", expQ.size(), 0);
    endtask

    initial begin
        rstN   = 1'b0;
        start  = '0;
        sValid = '0;
        sLast  = '0;
        for (int g = 0; g < 3; g++) begin
            romLen[g] = '0;
            sData[g]  = '0;
        end
        applyStimulus();
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
